// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_pkg
//  Description : Shared types and constants for the clk_div_sched divider
//                (scheduler state encoding, minimum legal divide ratio).
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    // Scheduler states: held idle, counting, counting with a staged ratio
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } div_state_t;

    // Smallest ratio that still yields both a high and a low phase
    localparam int MIN_RATIO = 2;

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_sched_if
//  Description : Control / status bundle of the clk_div_sched divider:
//                run enable, ratio request handshake and divided outputs.
//                Optional macro CLK_DIV_PCNT_EN adds the 16-bit period
//                counter signal pcnt.
//  Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_sched_if #(
    parameter int W = 8
);
    logic         en;
    logic         cfg_valid;
    logic [W-1:0] cfg_ratio;
    logic         cfg_ready;
    logic         cfg_err;
    logic         tick;
    logic         div_out;
    logic [W-1:0] cur_ratio;
    logic         pending;

`ifdef CLK_DIV_PCNT_EN
    logic [15:0]  pcnt;

    modport master (
        output en, cfg_valid, cfg_ratio,
        input  cfg_ready, cfg_err, tick, div_out, cur_ratio, pending, pcnt
    );

    modport slave (
        input  en, cfg_valid, cfg_ratio,
        output cfg_ready, cfg_err, tick, div_out, cur_ratio, pending, pcnt
    );
`else
    modport master (
        output en, cfg_valid, cfg_ratio,
        input  cfg_ready, cfg_err, tick, div_out, cur_ratio, pending
    );

    modport slave (
        input  en, cfg_valid, cfg_ratio,
        output cfg_ready, cfg_err, tick, div_out, cur_ratio, pending
    );
`endif

endinterface : clk_div_sched_if
`default_nettype wire

// File: rtl/div_period_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : div_period_cnt
//  Description : Period counter of the divider. Counts 0..N-1 and produces
//                the registered tick (last cycle of a period) and div_out
//                (high for the first floor(N/2) cycles). Decodes are made on
//                the next counter value so each registered output matches
//                the counter of the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_period_cnt #(
    parameter int W = 8
) (
    input  wire         clk,
    input  wire         rst_n,
    input  wire         run_cur,    // counting in the current cycle
    input  wire         run_nxt,    // counting in the next cycle
    input  wire [W-1:0] ratio_nxt,  // ratio in force in the next cycle
    output logic        tick,
    output logic        div_out
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         tick_q, tick_d;
    logic         div_q, div_d;

    // Next count and look-ahead decode of tick / div_out
    always_comb begin
        cnt_d = '0;
        // A period ends on tick, so tick_q doubles as the wrap condition;
        // a fresh start from idle also begins at zero.
        if (run_cur && run_nxt && !tick_q) begin
            cnt_d = cnt_q + W'(1);
        end
        tick_d = run_nxt && (cnt_d == (ratio_nxt - W'(1)));
        div_d  = run_nxt && (cnt_d < (ratio_nxt >> 1));
    end

    // Counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            div_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            div_q  <= div_d;
        end
    end

    assign tick    = tick_q;
    assign div_out = div_q;

endmodule : div_period_cnt
`default_nettype wire

// File: rtl/clk_div_sched.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_sched
//  Description : Programmable divide-ratio scheduler. Generates a one-cycle
//                tick enable and a registered divided waveform, and accepts
//                ratio changes over a valid/ready handshake that take effect
//                only at period boundaries (no runt periods).
//                Optional macro CLK_DIV_PCNT_EN adds a 16-bit count of
//                completed periods (pcnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int W         = 8,
    parameter int DEF_RATIO = 4
) (
    input  wire            clk,
    input  wire            rst_n,
    clk_div_sched_if.slave bus
);

    div_state_t   state_q, state_d;
    logic [W-1:0] cur_ratio_q, cur_ratio_d;
    logic [W-1:0] staged_q, staged_d;
    logic         cfg_err_q, cfg_err_d;

    logic         accept;
    logic         ratio_ok;
    logic         tick;
    logic         div_out;
    logic         run_cur;
    logic         run_nxt;

    assign accept   = bus.cfg_valid && (state_q != PEND);
    assign ratio_ok = (bus.cfg_ratio >= W'(MIN_RATIO));
    assign run_cur  = (state_q != IDLE);
    assign run_nxt  = (state_d != IDLE);

    // Next state, ratio scheduling and request error flag
    always_comb begin
        state_d     = state_q;
        cur_ratio_d = cur_ratio_q;
        staged_d    = staged_q;
        cfg_err_d   = accept && !ratio_ok;

        case (state_q)
            IDLE: begin
                if (accept && ratio_ok) begin
                    cur_ratio_d = bus.cfg_ratio;
                end
                if (bus.en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.en) begin
                    // Stopping: no period is running, so apply at once
                    state_d = IDLE;
                    if (accept && ratio_ok) begin
                        cur_ratio_d = bus.cfg_ratio;
                    end
                end else if (accept && ratio_ok) begin
                    if (tick) begin
                        // Request lands on the boundary: next period uses it
                        cur_ratio_d = bus.cfg_ratio;
                    end else begin
                        staged_d = bus.cfg_ratio;
                        state_d  = PEND;
                    end
                end
            end
            PEND: begin
                if (!bus.en) begin
                    cur_ratio_d = staged_q;
                    state_d     = IDLE;
                end else if (tick) begin
                    cur_ratio_d = staged_q;
                    state_d     = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scheduler state, ratio and error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_ratio_q <= W'(DEF_RATIO);
            staged_q    <= W'(DEF_RATIO);
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_ratio_q <= cur_ratio_d;
            staged_q    <= staged_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    div_period_cnt #(
        .W(W)
    ) u_period_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_cur   (run_cur),
        .run_nxt   (run_nxt),
        .ratio_nxt (cur_ratio_d),
        .tick      (tick),
        .div_out   (div_out)
    );

`ifdef CLK_DIV_PCNT_EN
    logic [15:0] pcnt_q, pcnt_d;

    // Completed-period count, cleared whenever the divider is idle
    always_comb begin
        pcnt_d = pcnt_q;
        if (!run_nxt) begin
            pcnt_d = '0;
        end else if (tick) begin
            pcnt_d = pcnt_q + 16'd1;
        end
    end

    // Period count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    assign bus.pcnt = pcnt_q;
`endif

    assign bus.cfg_ready = (state_q != PEND);
    assign bus.pending   = (state_q == PEND);
    assign bus.cur_ratio = cur_ratio_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.tick      = tick;
    assign bus.div_out   = div_out;

endmodule : clk_div_sched
`default_nettype wire

// File: tb/tb_clk_div_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div_sched
//  Description : Self-checking bench for clk_div_sched. Expected tick /
//                div_out values are queued per cycle when stimulus is driven
//                and compared at the falling edge of that cycle; each test
//                task also checks status signals inline. With
//                CLK_DIV_PCNT_EN defined the period counter is checked too.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_sched;

    localparam int W         = 8;
    localparam int DEF_RATIO = 4;
    // {tick, div_out, pending, cfg_ready, cfg_err, cur_ratio}
    localparam logic [W+4:0] RST_STATUS = {5'b00010, 8'd4};

    typedef struct {
        int   cyc;
        logic tick;
        logic div;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    clk_div_sched_if #(.W(W)) bus ();

    clk_div_sched #(
        .W         (W),
        .DEF_RATIO (DEF_RATIO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: compare queued waveform expectations for the current cycle
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL sb_stale entry for cycle %0d seen at cycle %0d", e.cyc, cyc);
            end else if (bus.tick !== e.tick || bus.div_out !== e.div) begin
                errors++;
                $display("FAIL wave cyc=%0d got tick=%0b div_out=%0b exp tick=%0b div_out=%0b",
                         cyc, bus.tick, bus.div_out, e.tick, e.div);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [W+4:0] status();
        return {bus.tick, bus.div_out, bus.pending, bus.cfg_ready, bus.cfg_err, bus.cur_ratio};
    endfunction

    // Queue expected tick/div_out for `count` cycles of period n from `start`
    task automatic push_period(input int start, input int n, input int count);
        exp_t e;
        for (int i = 0; i < count; i++) begin
            e.cyc  = start + i;
            e.tick = ((i % n) == (n - 1));
            e.div  = ((i % n) < (n / 2));
            sb_q.push_back(e);
        end
    endtask

    task automatic push_idle(input int c);
        exp_t e;
        e.cyc  = c;
        e.tick = 1'b0;
        e.div  = 1'b0;
        sb_q.push_back(e);
    endtask

    // Advance to 1 ns after the rising edge that starts cycle c
    task automatic to_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_run(output int origin);
        @(posedge clk);
        #1;
        bus.en = 1'b1;
        origin = cyc + 1;
    endtask

    task automatic stop_run();
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        push_idle(cyc + 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n         = 1'b0;
        bus.en        = 1'b0;
        bus.cfg_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int c;
        bus.en        = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_ratio = '0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (status() !== RST_STATUS) begin
            errors++;
            $display("FAIL reset_status got=%h exp=%h", status(), RST_STATUS);
        end
`ifdef CLK_DIV_PCNT_EN
        checks++;
        if (bus.pcnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_pcnt got=%0d exp=0", bus.pcnt);
        end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        c = cyc;
        push_idle(c + 1);
        push_idle(c + 2);
        to_cycle(c + 2);
    endtask

    task automatic test_default_run();
        int o;
        start_run(o);
        push_period(o, 4, 12);
        to_cycle(o + 11);
        @(negedge clk);
        checks++;
        if ({bus.pending, bus.cur_ratio} !== {1'b0, 8'd4}) begin
            errors++;
            $display("FAIL default_ratio got pending=%0b ratio=%0d exp pending=0 ratio=4",
                     bus.pending, bus.cur_ratio);
        end
        stop_run();
    endtask

    task automatic test_change_mid();
        int o;
        start_run(o);
        push_period(o, 4, 4);
        push_period(o + 4, 7, 14);
        to_cycle(o + 1);
        bus.cfg_valid = 1'b1;
        bus.cfg_ratio = 8'd7;
        to_cycle(o + 2);
        bus.cfg_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.pending, bus.cfg_ready} !== 2'b10) begin
            errors++;
            $display("FAIL mid_pend got pending=%0b ready=%0b exp pending=1 ready=0",
                     bus.pending, bus.cfg_ready);
        end
        to_cycle(o + 3);
        @(negedge clk);
        checks++;
        if ({bus.pending, bus.cfg_ready, bus.cur_ratio} !== {2'b10, 8'd4}) begin
            errors++;
            $display("FAIL mid_boundary got pending=%0b ready=%0b ratio=%0d exp 1 0 4",
                     bus.pending, bus.cfg_ready, bus.cur_ratio);
        end
        to_cycle(o + 4);
        @(negedge clk);
        checks++;
        if ({bus.pending, bus.cfg_ready, bus.cur_ratio} !== {2'b01, 8'd7}) begin
            errors++;
            $display("FAIL mid_applied got pending=%0b ready=%0b ratio=%0d exp 0 1 7",
                     bus.pending, bus.cfg_ready, bus.cur_ratio);
        end
        to_cycle(o + 17);
        stop_run();
    endtask

    task automatic test_change_at_tick();
        int o;
        do_reset();
        start_run(o);
        push_period(o, 4, 4);
        push_period(o + 4, 5, 10);
        to_cycle(o + 3);
        bus.cfg_valid = 1'b1;
        bus.cfg_ratio = 8'd5;
        @(negedge clk);
        checks++;
        if ({bus.pending, bus.tick} !== 2'b01) begin
            errors++;
            $display("FAIL tick_req got pending=%0b tick=%0b exp pending=0 tick=1",
                     bus.pending, bus.tick);
        end
        to_cycle(o + 4);
        bus.cfg_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.pending, bus.cur_ratio} !== {1'b0, 8'd5}) begin
            errors++;
            $display("FAIL tick_applied got pending=%0b ratio=%0d exp pending=0 ratio=5",
                     bus.pending, bus.cur_ratio);
        end
        for (int k = o + 5; k < o + 14; k++) begin
            to_cycle(k);
            @(negedge clk);
            checks++;
            if (bus.pending !== 1'b0) begin
                errors++;
                $display("FAIL tick_no_pend cyc=%0d got pending=%0b exp 0", k, bus.pending);
            end
        end
        stop_run();
    endtask

    task automatic test_bad_ratio();
        int o;
        do_reset();
        start_run(o);
        push_period(o, 4, 12);
        to_cycle(o + 1);
        bus.cfg_valid = 1'b1;
        bus.cfg_ratio = 8'd1;
        to_cycle(o + 2);
        bus.cfg_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.cfg_err, bus.pending, bus.cur_ratio} !== {2'b10, 8'd4}) begin
            errors++;
            $display("FAIL bad1_err got err=%0b pending=%0b ratio=%0d exp 1 0 4",
                     bus.cfg_err, bus.pending, bus.cur_ratio);
        end
        to_cycle(o + 3);
        @(negedge clk);
        checks++;
        if (bus.cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL bad1_pulse got err=%0b exp 0", bus.cfg_err);
        end
        to_cycle(o + 5);
        bus.cfg_valid = 1'b1;
        bus.cfg_ratio = 8'd0;
        to_cycle(o + 6);
        bus.cfg_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.cfg_err, bus.pending, bus.cur_ratio} !== {2'b10, 8'd4}) begin
            errors++;
            $display("FAIL bad0_err got err=%0b pending=%0b ratio=%0d exp 1 0 4",
                     bus.cfg_err, bus.pending, bus.cur_ratio);
        end
        to_cycle(o + 7);
        @(negedge clk);
        checks++;
        if (bus.cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL bad0_pulse got err=%0b exp 0", bus.cfg_err);
        end
        to_cycle(o + 11);
        @(negedge clk);
        checks++;
        if ({bus.pending, bus.cur_ratio} !== {1'b0, 8'd4}) begin
            errors++;
            $display("FAIL bad_ratio_kept got pending=%0b ratio=%0d exp 0 4",
                     bus.pending, bus.cur_ratio);
        end
        stop_run();
    endtask

    task automatic test_pend_then_stop();
        int o;
        int o2;
        do_reset();
        start_run(o);
        push_period(o, 4, 3);
        push_idle(o + 3);
        push_idle(o + 4);
        to_cycle(o + 1);
        bus.cfg_valid = 1'b1;
        bus.cfg_ratio = 8'd3;
        to_cycle(o + 2);
        bus.cfg_valid = 1'b0;
        bus.en        = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.pending !== 1'b1) begin
            errors++;
            $display("FAIL stop_pending got pending=%0b exp 1", bus.pending);
        end
        to_cycle(o + 3);
        @(negedge clk);
        checks++;
        if (status() !== {5'b00010, 8'd3}) begin
            errors++;
            $display("FAIL stop_idle got=%h exp=%h", status(), {5'b00010, 8'd3});
        end
        start_run(o2);
        push_period(o2, 3, 9);
        to_cycle(o2 + 8);
        @(negedge clk);
        checks++;
        if ({bus.pending, bus.cur_ratio} !== {1'b0, 8'd3}) begin
            errors++;
            $display("FAIL stop_rerun got pending=%0b ratio=%0d exp 0 3",
                     bus.pending, bus.cur_ratio);
        end
        stop_run();
    endtask

    task automatic test_boundary();
        int o;
        int c;
        do_reset();
        @(posedge clk);
        #1;
        bus.cfg_valid = 1'b1;
        bus.cfg_ratio = 8'd2;
        c = cyc;
        to_cycle(c + 1);
        bus.cfg_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.cfg_err, bus.cur_ratio} !== {1'b0, 8'd2}) begin
            errors++;
            $display("FAIL idle_load2 got err=%0b ratio=%0d exp 0 2", bus.cfg_err, bus.cur_ratio);
        end
        start_run(o);
        push_period(o, 2, 6);
        to_cycle(o + 5);
        stop_run();
        @(posedge clk);
        #1;
        bus.cfg_valid = 1'b1;
        bus.cfg_ratio = 8'd255;
        c = cyc;
        to_cycle(c + 1);
        bus.cfg_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cur_ratio !== 8'd255) begin
            errors++;
            $display("FAIL idle_load255 got ratio=%0d exp 255", bus.cur_ratio);
        end
        start_run(o);
        push_period(o, 255, 257);
        to_cycle(o + 256);
        @(negedge clk);
        checks++;
        if ({bus.pending, bus.cur_ratio} !== {1'b0, 8'd255}) begin
            errors++;
            $display("FAIL max_ratio got pending=%0b ratio=%0d exp 0 255",
                     bus.pending, bus.cur_ratio);
        end
        stop_run();
    endtask

    task automatic test_reset_in_pend();
        int o;
        int o2;
        do_reset();
        start_run(o);
        push_period(o, 4, 1);
        to_cycle(o);
        bus.cfg_valid = 1'b1;
        bus.cfg_ratio = 8'd7;
        to_cycle(o + 1);
        bus.cfg_valid = 1'b0;
        checks++;
        if ({bus.pending, bus.div_out} !== 2'b11) begin
            errors++;
            $display("FAIL rst_pre got pending=%0b div_out=%0b exp 1 1", bus.pending, bus.div_out);
        end
        #1;
        rst_n  = 1'b0;
        bus.en = 1'b0;
        #1;
        checks++;
        if (status() !== RST_STATUS) begin
            errors++;
            $display("FAIL rst_async got=%h exp=%h", status(), RST_STATUS);
        end
`ifdef CLK_DIV_PCNT_EN
        checks++;
        if (bus.pcnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_pcnt got=%0d exp=0", bus.pcnt);
        end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_run(o2);
        push_period(o2, 4, 13);
        for (int m = 0; m < 4; m++) begin
            to_cycle(o2 + 4 * m);
`ifdef CLK_DIV_PCNT_EN
            @(negedge clk);
            checks++;
            if (bus.pcnt !== 16'(m)) begin
                errors++;
                $display("FAIL pcnt_count cyc=%0d got=%0d exp=%0d", cyc, bus.pcnt, m);
            end
`endif
        end
        stop_run();
    endtask

    initial begin
        bus.en        = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_ratio = '0;

        test_reset();
        test_default_run();
        test_change_mid();
        test_change_at_tick();
        test_bad_ratio();
        test_pend_then_stop();
        test_boundary();
        test_reset_in_pend();

        to_cycle(cyc + 3);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d unchecked entries exp 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_clk_div_sched
`default_nettype wire

// File: doc/clk_div_sched.md
# clk_div_sched

Programmable divide-ratio scheduler for the counter library. It produces a single-cycle `tick` enable and a registered divided waveform `div_out` from the one system clock, so no derived clocks are needed. It accepts divide-ratio change requests over a valid/ready handshake and applies them only at output-period boundaries, so the output never produces a runt or truncated period. Downstream counters and blocks use `tick` as a clock enable in place of ripple-divided clocks.

## Interface
- `W`, 8: ratio width in bits.
- `DEF_RATIO`, 4: ratio loaded at reset. Must satisfy 2 ≤ DEF_RATIO ≤ 2^W−1.
- `clk` input 1: system clock. All flops are on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `en` input 1: run enable, level-sensitive.
- `cfg_valid` input 1: ratio request valid.
- `cfg_ratio` input W: requested divide ratio N.
- `cfg_ready` output 1: request can be accepted this cycle.
- `cfg_err` output 1: one-cycle pulse when an accepted request had N < 2.
- `tick` output 1: one-cycle pulse at the last cycle of each output period.
- `div_out` output 1: divided waveform, registered.
- `cur_ratio` output W: ratio currently in force.
- `pending` output 1: an accepted ratio is waiting for a period boundary.

## Operation
- States:
  - IDLE: counter held at 0, `tick` and `div_out` low.
  - RUN: counting.
  - PEND: counting, with a staged ratio waiting.
- Counter `cnt` (W bits) counts 0..N−1 and wraps to 0, where N = `cur_ratio`.
  - `tick` = 1 exactly in cycles where `cnt` == N−1.
  - `div_out` = 1 in cycles where `cnt` < N>>1. So it is high for floor(N/2) cycles and low for the remaining N − floor(N/2) cycles.
  - Both are flop outputs. Their value in a cycle matches the decode of `cnt` in that same cycle.
- State transitions:
  - IDLE→RUN when `en` = 1. The first cycle in RUN has `cnt` = 0.
  - RUN/PEND→IDLE when `en` = 0. `cnt`←0.
- Handshake:
  - `cfg_ready` = ~`pending`.
  - A request is accepted when `cfg_valid` & `cfg_ready`. `cfg_ratio` is sampled on that edge.
- Accepted request with N < 2: `cur_ratio` is unchanged. `cfg_err` pulses high the next cycle. There is no state change.
- Accepted request in IDLE: `cur_ratio`←N on the next edge.
- Accepted request in RUN:
  - Normally, N is staged, the state goes to PEND, and `pending` goes to 1.
  - If acceptance coincides with `tick`, N is applied directly at that boundary: the next cycle has `cnt` = 0 with the new N, the state stays RUN, and `pending` stays 0.
- In PEND, at the edge following `tick`: `cur_ratio`←staged, `cnt`←0, state→RUN, `pending`←0.
- `en` falling while in PEND: the staged ratio is applied immediately, state→IDLE.
- Boundary values:
  - N = 2: `tick` on every second cycle; `div_out` = 1,0,1,0,…
  - N = 2^W−1: maximum period. `cnt` compares never overflow.

## Timing
- Reset values:
  - `cnt` = 0, state IDLE.
  - `cur_ratio` = DEF_RATIO.
  - `tick`, `div_out`, `pending`, `cfg_err` = 0.
  - `cfg_ready` = 1.
- Reset asserted mid-period or in PEND: all of the above take effect immediately. The staged ratio is discarded.
- Latency from `en` high at edge t0: `div_out` rises in the cycle after t0. The first `tick` occurs N−1 cycles after that.
- Ratio change: the old period always completes in full. The new period starts the cycle after the boundary `tick`.

## Configuration
- `CLK_DIV_PCNT_EN`: when defined, adds output `pcnt` (16 bits).
  - It counts completed periods (increments on each `tick`) and wraps from 0xFFFF to 0.
  - It is cleared to 0 by reset and on entering IDLE.
- Without the macro: there is no `pcnt` port and no associated logic.

## Structure
- Shared package `clk_div_pkg`:
  - state enum `div_state_t` {IDLE, RUN, PEND};
  - constant `MIN_RATIO` = 2.
- One natural sub-module, `div_period_cnt`. It holds `cnt` and generates `tick` and `div_out` from `cur_ratio`.
- The top level holds the FSM, the handshake and the staged-ratio register.

## Test plan
- Reset, then `en` = 1 with DEF_RATIO = 4 → `div_out` = 1,1,0,0 repeating; `tick` on every 4th cycle; `cur_ratio` = 4.
- Request N = 7 mid-period in RUN:
  - `pending` = 1 and `cfg_ready` = 0 until the next `tick`.
  - Then periods are 7 cycles with `div_out` high 3, low 4.
  - No period shorter than 4 appears.
- Request N = 5 in the same cycle as `tick` → the very next period is 5 cycles long; `pending` never asserts.
- Request N = 1 or N = 0 → `cfg_err` pulses for 1 cycle; `cur_ratio` stays 4; the waveform is unchanged.
- Stage N = 3 in PEND, then drop `en` → IDLE next cycle, outputs low, `cur_ratio` = 3. Raise `en` → period is 3 cycles.
- Assert `rst_n` = 0 mid-period while in PEND → all outputs are at reset values immediately, `cur_ratio` = 4, and the staged value is lost. With `CLK_DIV_PCNT_EN` defined, `pcnt` = 0 after reset and counts 1,2,3 on successive ticks.
